rtc_sync_ctrl: RTL and testbench

Sequencer and format converter on the host side of the PCF8563 I2C engine. Issues periodic `rtc_get` pulses and host-initiated `rtc_set` pulses to the engine, holding `rtc_in` stable for the whole write. Captures the engine's 56-bit raw register image, strips PCF8563 status and unused bits, validates the BCD, and presents a clean 64-bit time word to the menu/ARM interface.

---
 rtl/rtc_pkg.sv | 46 ++++
 rtl/rtc_bcd_check.sv | 36 +++
 rtl/rtc_sync_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rtc_sync_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared types and constants for the PCF8563 host-side sequencer.
// Byte-lane indices count from the least significant byte of each bus.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SET_PULSE = 3'd1,
    ST_SET_WAIT  = 3'd2,
    ST_GET_PULSE = 3'd3,
    ST_GET_WAIT  = 3'd4,
    ST_CAPTURE   = 3'd5
  } state_t;

  // Engine register image {s, m, h, d, wd, cm, y}
  localparam int RAW_SEC = 6;
  localparam int RAW_MIN = 5;
  localparam int RAW_HR  = 4;
  localparam int RAW_DAY = 3;
  localparam int RAW_WD  = 2;
  localparam int RAW_CM  = 1;
  localparam int RAW_YR  = 0;

  // Host time word {8'h00, wd, yr, mo, day, hr, min, sec}
  localparam int TM_SEC = 0;
  localparam int TM_MIN = 1;
  localparam int TM_HR  = 2;
  localparam int TM_DAY = 3;
  localparam int TM_MO  = 4;
  localparam int TM_YR  = 5;
  localparam int TM_WD  = 6;

  localparam logic [7:0] MASK_SEC = 8'h7F;
  localparam logic [7:0] MASK_MIN = 8'h7F;
  localparam logic [7:0] MASK_HR  = 8'h3F;
  localparam logic [7:0] MASK_DAY = 8'h3F;
  localparam logic [7:0] MASK_WD  = 8'h07;
  localparam logic [7:0] MASK_MO  = 8'h1F;

  localparam int BIT_VL      = 7;
  localparam int BIT_CENTURY = 7;

  function automatic logic bcd_byte_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_bcd_check.sv
// Combinational validity of seven masked time bytes. With RTC_BCD_CHECK_EN
// undefined the body reduces to a constant pass.
module rtc_bcd_check
  import rtc_pkg::*;
(
  input  logic [7:0] sec,
  input  logic [7:0] mins,
  input  logic [7:0] hr,
  input  logic [7:0] day,
  input  logic [7:0] wd,
  input  logic [7:0] mo,
  input  logic [7:0] yr,
  output logic       ok
);

`ifdef RTC_BCD_CHECK_EN
  logic digits_ok;
  logic range_ok;

  assign digits_ok = bcd_byte_ok(sec) && bcd_byte_ok(mins) && bcd_byte_ok(hr) &&
                     bcd_byte_ok(day) && bcd_byte_ok(wd) && bcd_byte_ok(mo) &&
                     bcd_byte_ok(yr);

  // Valid BCD orders the same as binary, so ranges compare on the raw byte
  assign range_ok = (sec < 8'h60) && (mins < 8'h60) && (hr < 8'h24) &&
                    (day >= 8'h01) && (day <= 8'h31) &&
                    (mo >= 8'h01) && (mo <= 8'h12) && (wd <= 8'h06);

  assign ok = digits_ok && range_ok;
`else
  logic unused_bytes;
  assign unused_bytes = ^{sec, mins, hr, day, wd, mo, yr};
  assign ok = 1'b1;
`endif

endmodule

// File: rtl/rtc_sync_ctrl.sv
// Host-side sequencer for the PCF8563 engine: periodic/host get and set pulses,
// raw image capture and cleanup. Optional BCD/range checking via RTC_BCD_CHECK_EN.
module rtc_sync_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned POLL_CYCLES   = 50_000_000,
  parameter int unsigned SETTLE_CYCLES = 32768
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        set_req,
  input  logic [63:0] set_time,
  output logic        set_ack,
  output logic [63:0] rtc_time,
  output logic        rtc_valid,
  output logic        rtc_century,
  output logic        busy,
  output logic        rtc_get,
  output logic        rtc_set,
  output logic [55:0] rtc_in,
  input  logic [55:0] rtc_raw
);

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES);
  localparam logic [31:0] POLL_LOAD   = (POLL_CYCLES > 0) ? 32'(POLL_CYCLES - 1) : 32'd0;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] settle_cnt;
  logic [31:0] poll_cnt;
  logic        settle_done;
  logic        poll_expired;
  logic        latch_go;
  logic        get_go;
  logic        set_go;
  logic        capture_go;
  logic        waiting;

  logic [7:0]  cap_sec, cap_min, cap_hr, cap_day, cap_wd, cap_mo, cap_yr;
  logic        cap_vl;
  logic        cap_century;
  logic        check_ok;
  logic        cap_good;

  logic [7:0]  wr_sec, wr_min, wr_hr, wr_day, wr_wd, wr_mo, wr_yr;
  logic        unused_rsv;

  assign settle_done  = (settle_cnt == SETTLE_LAST);
  assign poll_expired = (poll_cnt == 32'd0);

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (set_req)           state_nxt = ST_SET_PULSE;
        else if (poll_expired) state_nxt = ST_GET_PULSE;
      end
      ST_SET_PULSE: state_nxt = ST_SET_WAIT;
      ST_SET_WAIT:  if (settle_done) state_nxt = ST_GET_PULSE;
      ST_GET_PULSE: state_nxt = ST_GET_WAIT;
      ST_GET_WAIT:  if (settle_done) state_nxt = ST_CAPTURE;
      ST_CAPTURE:   state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    latch_go   = (state == ST_IDLE) && set_req;
    set_go     = (state == ST_SET_PULSE);
    get_go     = (state == ST_GET_PULSE);
    capture_go = (state == ST_CAPTURE);
    waiting    = (state == ST_SET_WAIT) || (state == ST_GET_WAIT);
  end

  // Pulses are registered, so each lands one cycle after its deciding state
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      set_ack <= 1'b0;
      rtc_set <= 1'b0;
      rtc_get <= 1'b0;
    end else begin
      set_ack <= latch_go;
      rtc_set <= set_go;
      rtc_get <= get_go;
    end
  end

  // Wait states last SETTLE_CYCLES+1 cycles: the count runs 0..SETTLE_CYCLES
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset)       settle_cnt <= 32'd0;
    else if (waiting) settle_cnt <= settle_cnt + 32'd1;
    else              settle_cnt <= 32'd0;
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset)             poll_cnt <= 32'd0;
    else if (capture_go)    poll_cnt <= POLL_LOAD;
    else if (!poll_expired) poll_cnt <= poll_cnt - 32'd1;
  end

  assign cap_sec     = rtc_raw[RAW_SEC*8 +: 8] & MASK_SEC;
  assign cap_min     = rtc_raw[RAW_MIN*8 +: 8] & MASK_MIN;
  assign cap_hr      = rtc_raw[RAW_HR*8  +: 8] & MASK_HR;
  assign cap_day     = rtc_raw[RAW_DAY*8 +: 8] & MASK_DAY;
  assign cap_wd      = rtc_raw[RAW_WD*8  +: 8] & MASK_WD;
  assign cap_mo      = rtc_raw[RAW_CM*8  +: 8] & MASK_MO;
  assign cap_yr      = rtc_raw[RAW_YR*8  +: 8];
  assign cap_vl      = rtc_raw[RAW_SEC*8 + BIT_VL];
  assign cap_century = rtc_raw[RAW_CM*8 + BIT_CENTURY];

  rtc_bcd_check u_bcd_check (
    .sec  (cap_sec),
    .mins (cap_min),
    .hr   (cap_hr),
    .day  (cap_day),
    .wd   (cap_wd),
    .mo   (cap_mo),
    .yr   (cap_yr),
    .ok   (check_ok)
  );

  assign cap_good = !cap_vl && check_ok;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      rtc_time    <= 64'd0;
      rtc_valid   <= 1'b0;
      rtc_century <= 1'b0;
    end else if (capture_go) begin
      if (cap_good) begin
        rtc_time                  <= 64'd0;
        rtc_time[TM_SEC*8 +: 8]   <= cap_sec;
        rtc_time[TM_MIN*8 +: 8]   <= cap_min;
        rtc_time[TM_HR*8  +: 8]   <= cap_hr;
        rtc_time[TM_DAY*8 +: 8]   <= cap_day;
        rtc_time[TM_MO*8  +: 8]   <= cap_mo;
        rtc_time[TM_YR*8  +: 8]   <= cap_yr;
        rtc_time[TM_WD*8  +: 8]   <= cap_wd;
        rtc_century               <= cap_century;
        rtc_valid                 <= 1'b1;
      end else begin
        rtc_valid <= 1'b0;
      end
    end
  end

  // Host write image; the century bit is carried over from the last good read
  assign wr_sec = set_time[TM_SEC*8 +: 8] & MASK_SEC;
  assign wr_min = set_time[TM_MIN*8 +: 8] & MASK_MIN;
  assign wr_hr  = set_time[TM_HR*8  +: 8] & MASK_HR;
  assign wr_day = set_time[TM_DAY*8 +: 8] & MASK_DAY;
  assign wr_wd  = set_time[TM_WD*8  +: 8] & MASK_WD;
  assign wr_mo  = (set_time[TM_MO*8 +: 8] & MASK_MO) | {rtc_century, 7'd0};
  assign wr_yr  = set_time[TM_YR*8  +: 8];

  assign unused_rsv = ^set_time[63:56];

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      rtc_in <= 56'd0;
    end else if (latch_go) begin
      rtc_in[RAW_SEC*8 +: 8] <= wr_sec;
      rtc_in[RAW_MIN*8 +: 8] <= wr_min;
      rtc_in[RAW_HR*8  +: 8] <= wr_hr;
      rtc_in[RAW_DAY*8 +: 8] <= wr_day;
      rtc_in[RAW_WD*8  +: 8] <= wr_wd;
      rtc_in[RAW_CM*8  +: 8] <= wr_mo;
      rtc_in[RAW_YR*8  +: 8] <= wr_yr;
    end
  end

endmodule

// File: tb/tb_rtc_sync_ctrl.sv
// Directed bench for rtc_sync_ctrl with shortened poll/settle periods.
// Expectations follow the RTC_BCD_CHECK_EN setting of the build.
module tb_rtc_sync_ctrl;

  localparam int S = 8;
  localparam int P = 60;

  logic        mclk = 1'b0;
  logic        reset = 1'b0;
  logic        set_req = 1'b0;
  logic [63:0] set_time = 64'd0;
  logic [55:0] rtc_raw = 56'd0;
  logic        set_ack, rtc_valid, rtc_century, busy, rtc_get, rtc_set;
  logic [63:0] rtc_time;
  logic [55:0] rtc_in;

  int checks = 0;
  int errors = 0;

  rtc_sync_ctrl #(.POLL_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .mclk        (mclk),
    .reset       (reset),
    .set_req     (set_req),
    .set_time    (set_time),
    .set_ack     (set_ack),
    .rtc_time    (rtc_time),
    .rtc_valid   (rtc_valid),
    .rtc_century (rtc_century),
    .busy        (busy),
    .rtc_get     (rtc_get),
    .rtc_set     (rtc_set),
    .rtc_in      (rtc_in),
    .rtc_raw     (rtc_raw)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    logic [55:0] raw;
    logic [63:0] t;
    logic        v;
    logic        c;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_get(output int cyc);
    cyc = -1;
    for (int i = 1; i <= P + 4*S + 20; i++) begin
      @(negedge mclk);
      if (rtc_get) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    logic [63:0] prev_t;
    logic        prev_v, prev_c;
    int          cyc, cnt, bad;
    logic [55:0] exp_in;

    vecs[0] = '{56'h30_15_09_21_03_07_24, 64'h00_03_24_07_21_09_15_30, 1'b1, 1'b0};
    vecs[1] = '{56'hB0_15_09_21_03_07_24, 64'h00_03_24_07_21_09_15_30, 1'b0, 1'b0};
    vecs[3] = '{56'h45_D9_E3_F1_FE_92_99, 64'h00_06_99_12_31_23_59_45, 1'b1, 1'b1};
    vecs[5] = '{56'h59_59_23_01_00_01_00, 64'h00_00_00_01_01_23_59_59, 1'b1, 1'b0};
`ifdef RTC_BCD_CHECK_EN
    vecs[2] = '{56'h30_15_25_21_03_07_24, 64'h00_03_24_07_21_09_15_30, 1'b0, 1'b0};
    vecs[4] = '{56'h00_00_00_00_00_00_00, 64'h00_06_99_12_31_23_59_45, 1'b0, 1'b1};
    vecs[6] = '{56'h5A_00_00_01_00_01_00, 64'h00_00_00_01_01_23_59_59, 1'b0, 1'b0};
`else
    vecs[2] = '{56'h30_15_25_21_03_07_24, 64'h00_03_24_07_21_25_15_30, 1'b1, 1'b0};
    vecs[4] = '{56'h00_00_00_00_00_00_00, 64'h00_00_00_00_00_00_00_00, 1'b1, 1'b0};
    vecs[6] = '{56'h5A_00_00_01_00_01_00, 64'h00_00_00_01_01_00_00_5A, 1'b1, 1'b0};
`endif

    // Reset state
    repeat (3) @(negedge mclk);
    chk("rst_time", rtc_time, 64'd0);
    chk("rst_valid", rtc_valid, 1'b0);
    chk("rst_century", rtc_century, 1'b0);
    chk("rst_in", rtc_in, 56'd0);
    chk("rst_ack", set_ack, 1'b0);
    chk("rst_get", rtc_get, 1'b0);
    chk("rst_set", rtc_set, 1'b0);
    chk("rst_busy", busy, 1'b0);

    rtc_raw = vecs[0].raw;
    reset = 1'b1;
    @(negedge mclk);
    chk("first_busy", busy, 1'b1);
    chk("first_get_early", rtc_get, 1'b0);

    prev_t = 64'd0; prev_v = 1'b0; prev_c = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rtc_raw = vecs[i].raw;
      wait_get(cyc);
      chk($sformatf("get_gap%0d", i), cyc, (i == 0) ? 64'd1 : 64'(P + 1));
      repeat (S + 1) @(negedge mclk);
      chk($sformatf("pre_time%0d", i), rtc_time, prev_t);
      chk($sformatf("pre_valid%0d", i), rtc_valid, prev_v);
      @(negedge mclk);
      chk($sformatf("time%0d", i), rtc_time, vecs[i].t);
      chk($sformatf("valid%0d", i), rtc_valid, vecs[i].v);
      chk($sformatf("century%0d", i), rtc_century, vecs[i].c);
      chk($sformatf("idle%0d", i), busy, 1'b0);
      prev_t = vecs[i].t; prev_v = vecs[i].v; prev_c = vecs[i].c;
    end

    // Host set with century clear; set_time is scrambled after the ack
    rtc_raw = 56'h45_D9_E3_F1_FE_92_99;
    set_time = 64'h00_05_99_12_31_23_59_58;
    set_req = 1'b1;
    @(negedge mclk);
    chk("set_ack", set_ack, 1'b1);
    chk("set_ack_no_set", rtc_set, 1'b0);
    set_req = 1'b0;
    set_time = '1;
    @(negedge mclk);
    chk("set_pulse", rtc_set, 1'b1);
    chk("set_ack_once", set_ack, 1'b0);
    exp_in = 56'h58_59_23_31_05_12_99;
    chk("set_in", rtc_in, exp_in);
    bad = 0; cnt = 0;
    repeat (S + 1) begin
      @(negedge mclk);
      if (rtc_in !== exp_in) bad++;
      if (rtc_get || rtc_set) cnt++;
    end
    chk("set_in_held", bad, 0);
    chk("set_wait_quiet", cnt, 0);
    @(negedge mclk);
    chk("readback_get", rtc_get, 1'b1);
    repeat (S + 2) @(negedge mclk);
    chk("readback_time", rtc_time, 64'h00_06_99_12_31_23_59_45);
    chk("readback_century", rtc_century, 1'b1);

    // set_req raised in the cycle the poll timer expires
    repeat (P - 1) @(negedge mclk);
    set_time = 64'h00_01_25_03_14_08_30_00;
    set_req = 1'b1;
    @(negedge mclk);
    chk("coinc_ack", set_ack, 1'b1);
    chk("coinc_no_get", rtc_get, 1'b0);
    set_req = 1'b0;
    @(negedge mclk);
    chk("coinc_set", rtc_set, 1'b1);
    chk("coinc_in_century", rtc_in, 56'h00_30_08_14_01_83_25);
    cnt = 0;
    repeat (S + 2) begin
      @(negedge mclk);
      if (rtc_get) cnt++;
    end
    chk("coinc_get_count", cnt, 1);
    chk("coinc_readback", rtc_get, 1'b1);
    repeat (S + 2) @(negedge mclk);
    chk("coinc_valid", rtc_valid, 1'b1);

    // set_req during GET_WAIT is held off until the next IDLE
    wait_get(cyc);
    chk("poll_gap", cyc, 64'(P + 1));
    set_time = 64'h00_05_99_12_31_23_59_58;
    set_req = 1'b1;
    cnt = 0;
    repeat (S + 2) begin
      @(negedge mclk);
      if (set_ack) cnt++;
    end
    chk("busy_no_ack", cnt, 0);
    @(negedge mclk);
    chk("late_ack", set_ack, 1'b1);
    set_req = 1'b0;
    cnt = 0;
    repeat (S + 4) begin
      @(negedge mclk);
      if (rtc_set) cnt++;
    end
    chk("late_set_count", cnt, 1);
    chk("late_in", rtc_in, 56'h58_59_23_31_05_92_99);

    // Reset in the middle of the readback
    reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge mclk);
      if (busy || rtc_get || rtc_set || set_ack || rtc_valid || rtc_century ||
          rtc_time != 64'd0 || rtc_in != 56'd0) bad++;
    end
    chk("midreset_quiet", bad, 0);
    rtc_raw = vecs[0].raw;
    reset = 1'b1;
    @(negedge mclk);
    chk("rerun_busy", busy, 1'b1);
    @(negedge mclk);
    chk("rerun_get", rtc_get, 1'b1);
    repeat (S + 2) @(negedge mclk);
    chk("rerun_time", rtc_time, vecs[0].t);
    chk("rerun_valid", rtc_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
